beta_mem_responder: RTL
=======================

Name: beta_mem_responder

Overview:
Memory-side responder for the Beta's single bidirectional memory port. It consumes ma/mdout/mwe and produces mdin with one-cycle synchronous read latency, and serves both instruction fetch and LD/ST. It also decodes a memory-mapped I/O page holding three things:
- a laser-point FIFO that feeds the galvo/DAC driver,
- a periodic timer,
- the irq/xadr interrupt source back to the CPU.

Parameters:
AW, 12, RAM word-address width (2^AW 32-bit words).
FIFO_LOG2, 4, log2 of point FIFO depth (depth 16).
IO_PAGE, 15'h7FFF, value of ma[30:16] that selects the I/O page.
IRQ_VEC, 31'h00000008, constant driven on xadr.

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
ma  in  32  CPU address; bit 31 (supervisor) ignored, bits 1:0 ignored
mdout  in  32  CPU write data, valid when mwe=1
mwe  in  1  write strobe, sampled at the same edge as ma/mdout
mdin  out  32  read data, valid the cycle after ma is presented
irq  out  1  level interrupt request to CPU
xadr  out  31  interrupt vector, tied to IRQ_VEC
pt_data  out  32  FIFO head word to point driver
pt_valid  out  1  FIFO non-empty
pt_ready  in  1  driver accepts head word when pt_valid & pt_ready

Behaviour:
- Reset (reset_n=0, async) sets:
  - mdin=0, irq=0, pt_valid=0, pt_data=0;
  - FIFO empty, overflow=0;
  - timer reload=0, counter=0, pending=0, irq enable=0.
  - RAM contents are not reset.
- Decode: io = (ma[30:16]==IO_PAGE); ram index = ma[AW+1:2]; register offset = ma[3:2].
- Read path:
  - Every cycle, the responder registers the read select (io/ram and offset).
  - mdin in cycle N+1 reflects the address presented in cycle N, whether or not mwe was high.
  - RAM uses a synchronous read port.
- Write path: on a clock edge with mwe=1 the write commits to RAM or to the selected I/O register. A write in cycle N followed by a read of the same address in N+1 returns the new data.
- RAM wrap: addresses outside the I/O page alias modulo 2^AW words.
- I/O registers (word offsets):
  - 0 PTFIFO:
    - Write pushes mdout; a read returns 0.
    - A push when full is dropped and sets sticky overflow.
  - 1 STATUS:
    - Read layout: [0]=full, [1]=empty, [2]=overflow, [3]=timer pending, [FIFO_LOG2+8:8]=occupancy count (0..depth); other bits 0.
    - Any write clears overflow.
  - 2 TIMER:
    - A write sets reload=mdout and loads counter=mdout. A read returns the live counter.
    - reload=0 disables the timer.
  - 3 IRQCTL:
    - Read returns {30'b0, pending, enable}.
    - Write: bit0 sets enable; bit1=1 clears pending (ack).
- Timer:
  - While reload≠0, the counter decrements each cycle.
  - When the counter is 0, it reloads from reload and pending is set on that edge.
  - If an expiry and an ack land on the same edge, the expiry wins and pending stays 1.
- irq = pending & enable, registered. It stays asserted until acked or disabled.
- FIFO:
  - pt_data = head word (first-word-fall-through); pt_valid = !empty.
  - Pop happens on pt_valid & pt_ready.
  - A push and a pop on the same edge both take effect and the count is unchanged. This holds when full, so a push to a full FIFO that is popping on the same edge is accepted.
  - Pointers wrap modulo depth. Count width is FIFO_LOG2+1.
- Async reset mid-transaction aborts any write in flight; FIFO contents are discarded.

Decomposition:
- Shared package beta_mem_pkg holds:
  - the IO_PAGE default;
  - register offset constants (REG_PTFIFO=0, REG_STATUS=1, REG_TIMER=2, REG_IRQCTL=3);
  - STATUS bit positions and IRQCTL bit positions.
- One sub-module, point_fifo:
  - parameterised by FIFO_LOG2;
  - push/data in, pop/data out;
  - full, empty, count.
- Top level holds the RAM array, decode, timer and read mux.

Test Plan:
- RAM round trip: mwe=1, ma=0x100, mdout=0xDEADBEEF; next cycle ma=0x100 -> mdin=0xDEADBEEF that cycle+1. ma=0x80000100 -> same data (bit 31 ignored).
- Read latency: present ma=0x0 then ma=0x4 on back-to-back cycles with RAM {0x11,0x22} -> mdin=0x11 then 0x22, each one cycle after its address.
- FIFO fill/overflow, pt_ready=0: 17 writes to PTFIFO -> STATUS reads full=1, overflow=1, count=16. Then pt_ready=1 -> 16 pops in order, pt_valid=0 after the 16th. A STATUS write clears overflow.
- Simultaneous push/pop: with count=16 and pt_ready=1, push 0xABCD -> count stays 16 and 0xABCD appears as the 16th subsequent pop.
- Timer/irq: IRQCTL=1, TIMER=3 -> pending and irq rise 4 and 5 cycles after the write edge respectively, and repeat every 4 cycles. IRQCTL write 0x3 on the expiry edge -> pending stays 1. xadr=0x00000008 throughout.
- Async reset: drop reset_n mid-FIFO-drain -> pt_valid=0, irq=0, mdin=0 immediately (no clock edge); after release STATUS reads empty=1, count=0.

Source files
------------

// File: rtl/beta_mem_pkg.sv
// beta_mem_pkg: shared constants for the Beta memory responder (I/O page, register offsets, bit positions)
package beta_mem_pkg;
   localparam logic [14:0] IO_PAGE_DEF = 15'h7FFF;
   localparam logic [30:0] IRQ_VEC_DEF = 31'h00000008;
   localparam logic [1:0]  REG_PTFIFO  = 2'd0;
   localparam logic [1:0]  REG_STATUS  = 2'd1;
   localparam logic [1:0]  REG_TIMER   = 2'd2;
   localparam logic [1:0]  REG_IRQCTL  = 2'd3;
   localparam int          ST_FULL     = 0;
   localparam int          ST_EMPTY    = 1;
   localparam int          ST_OVF      = 2;
   localparam int          ST_PEND     = 3;
   localparam int          ST_COUNT    = 8;
   localparam int          IRQ_EN      = 0;
   localparam int          IRQ_PEND    = 1;
endpackage

// File: rtl/point_fifo.sv
// point_fifo: first-word-fall-through FIFO of 32-bit laser points
//   clk, reset_n  : clock, async active-low reset
//   push_i/push_data_i : push strobe and word (dropped when full unless popping)
//   pop_i         : consume head word (ignored when empty)
//   pop_data_o    : head word, 0 when empty
//   full_o, empty_o, count_o : occupancy flags and count (0..depth)
module point_fifo #(
   parameter int FIFO_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 push_i,
   input  logic [31:0]          push_data_i,
   input  logic                 pop_i,
   output logic [31:0]          pop_data_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [FIFO_LOG2:0]   count_o
);
   localparam int CW = FIFO_LOG2 + 1;
   localparam logic [FIFO_LOG2:0] DEPTH = CW'(2 ** FIFO_LOG2);
   logic [31:0]          mem [2 ** FIFO_LOG2];
   logic [FIFO_LOG2-1:0] wr_q, rd_q;
   logic [FIFO_LOG2:0]   cnt_q;
   logic                 do_push, do_pop;
   assign full_o     = cnt_q == DEPTH;
   assign empty_o    = cnt_q == '0;
   assign count_o    = cnt_q;
   assign do_pop     = pop_i & ~empty_o;
   // a pop on the same edge frees the slot, so a full FIFO still accepts the push
   assign do_push    = push_i & (~full_o | do_pop);
   assign pop_data_o = empty_o ? 32'b0 : mem[rd_q];
   always_ff @(posedge clk)
      if (do_push) mem[wr_q] <= push_data_i;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + FIFO_LOG2'(do_push);
         rd_q  <= rd_q + FIFO_LOG2'(do_pop);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/beta_mem_responder.sv
// beta_mem_responder: Beta memory-port responder with RAM, point FIFO, timer and interrupt source
//   clk, reset_n        : clock, async active-low reset
//   ma, mdout, mwe      : CPU address, write data, write strobe
//   mdin                : read data, valid one cycle after ma
//   irq, xadr           : registered interrupt request and fixed vector
//   pt_data, pt_valid, pt_ready : point FIFO head handshake to the galvo/DAC driver
module beta_mem_responder
   import beta_mem_pkg::*;
#(
   parameter int          AW        = 12,
   parameter int          FIFO_LOG2 = 4,
   parameter logic [14:0] IO_PAGE   = IO_PAGE_DEF,
   parameter logic [30:0] IRQ_VEC   = IRQ_VEC_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] ma,
   input  logic [31:0] mdout,
   input  logic        mwe,
   output logic [31:0] mdin,
   output logic        irq,
   output logic [30:0] xadr,
   output logic [31:0] pt_data,
   output logic        pt_valid,
   input  logic        pt_ready
);
   localparam int CW = FIFO_LOG2 + 1;
   logic [31:0]   mem [2 ** AW];
   logic          io, ram_we, wr_fifo, wr_status, wr_timer, wr_irqctl, pop;
   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic          full, empty;
   logic [CW-1:0] count;
   logic          io_q, irq_q, expire;
   logic [1:0]    off_q;
   logic [31:0]   ram_rd_q, reload_q, reload_d, cnt_q, cnt_d, status, irqctl, io_rd;
   logic          pend_q, pend_d, en_q, en_d, ovf_q, ovf_d;
   logic          unused_bits;
   assign unused_bits = ^{ma[31], ma[15:4], ma[1:0]};
   assign io        = ma[30:16] == IO_PAGE;
   assign idx       = ma[AW+1:2];
   assign off       = ma[3:2];
   // a write still on the bus while reset is asserted must not land in RAM
   assign ram_we    = mwe & ~io & reset_n;
   assign wr_fifo   = mwe & io & (off == REG_PTFIFO);
   assign wr_status = mwe & io & (off == REG_STATUS);
   assign wr_timer  = mwe & io & (off == REG_TIMER);
   assign wr_irqctl = mwe & io & (off == REG_IRQCTL);
   assign pop       = pt_valid & pt_ready;
   assign pt_valid  = ~empty;
   assign irq       = irq_q;
   assign xadr      = IRQ_VEC;
   point_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (wr_fifo),
      .push_data_i (mdout),
      .pop_i       (pop),
      .pop_data_o  (pt_data),
      .full_o      (full),
      .empty_o     (empty),
      .count_o     (count)
   );
   always_comb begin
      reload_d = reload_q;
      cnt_d    = cnt_q;
      expire   = 1'b0;
      if (wr_timer) begin
         reload_d = mdout;
         cnt_d    = mdout;
      end else if (reload_q != '0) begin
         expire = cnt_q == '0;
         cnt_d  = expire ? reload_q : cnt_q - 32'd1;
      end
      // expiry beats a simultaneous ack so no tick is lost
      pend_d = expire | (pend_q & ~(wr_irqctl & mdout[IRQ_PEND]));
      en_d   = wr_irqctl ? mdout[IRQ_EN] : en_q;
      // a push to a full FIFO is dropped only when nothing pops on the same edge
      ovf_d  = (ovf_q & ~wr_status) | (wr_fifo & full & ~pop);
   end
   always_comb begin
      status                = '0;
      status[ST_FULL]       = full;
      status[ST_EMPTY]      = empty;
      status[ST_OVF]        = ovf_q;
      status[ST_PEND]       = pend_q;
      status[ST_COUNT +: CW] = count;
      irqctl                = '0;
      irqctl[IRQ_EN]        = en_q;
      irqctl[IRQ_PEND]      = pend_q;
      io_rd = off_q == REG_STATUS ? status :
              off_q == REG_TIMER  ? cnt_q  :
              off_q == REG_IRQCTL ? irqctl : 32'b0;
   end
   // only the select is registered; I/O reads show register state after the edge
   assign mdin = io_q ? io_rd : ram_rd_q;
   always_ff @(posedge clk)
      if (ram_we) mem[idx] <= mdout;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         io_q     <= 1'b0;
         off_q    <= '0;
         ram_rd_q <= '0;
         reload_q <= '0;
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         en_q     <= 1'b0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         io_q     <= io;
         off_q    <= off;
         ram_rd_q <= mem[idx];
         reload_q <= reload_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         en_q     <= en_d;
         ovf_q    <= ovf_d;
         irq_q    <= pend_q & en_q;
      end
endmodule
